// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: FSM state encoding, nibble width and
// a helper for sizing the nibble index counter.
package arith_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width of a counter that walks width/4 nibbles, never below 1 bit.
    function automatic int idx_w(input int width);
        int n;
        n = width / NIBBLE_W;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Request/result bundle for nibble_serial_adder.
// NIBBLE_SERIAL_ADDER_OVERFLOW_EN adds the signed-overflow flag ovf.
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
    logic             ovf;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, ovf
    );
    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, ovf
    );
`else
    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );
    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
`endif
endinterface

// File: rtl/cla.sv
// 4-bit carry look-ahead adder: the combinational nibble slice
// reused by the serial adder.
module cla (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] Sum,
    output logic       Cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic       c1;
    logic       c2;
    logic       c3;

    // Generate/propagate terms and flattened look-ahead carries.
    always_comb begin
        g    = A & B;
        p    = A ^ B;
        c1   = g[0] | (p[0] & Cin);
        c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
        c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & Cin);
        Cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & Cin);
        Sum  = p ^ {c3, c2, c1, Cin};
    end
endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder pushing one nibble per clock through cla.
// NIBBLE_SERIAL_ADDER_OVERFLOW_EN adds a registered signed-overflow flag.
module nibble_serial_adder
    import arith_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    nibble_serial_adder_if.slave bus
);
    localparam int NIB = WIDTH / NIBBLE_W;
    localparam int IW  = idx_w(WIDTH);

    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
        $error("nibble_serial_adder: WIDTH must be a multiple of 4, >= 4");
    end

    state_e           state_q, state_d;
    logic             carry_q, carry_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] psum_q, psum_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic [3:0]       cla_sum;
    logic             cla_cout;
    logic [WIDTH-1:0] psum_next;

    cla u_cla (
        .A    (opa_q[NIBBLE_W-1:0]),
        .B    (opb_q[NIBBLE_W-1:0]),
        .Cin  (carry_q),
        .Sum  (cla_sum),
        .Cout (cla_cout)
    );

`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
    // Operand MSBs are kept aside since the operand regs shift away.
    logic amsb_q, amsb_d;
    logic bmsb_q, bmsb_d;
    logic ovf_q, ovf_d;
`endif

    // Next-state, shift and result assembly.
    always_comb begin
        state_d   = state_q;
        carry_d   = carry_q;
        idx_d     = idx_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        psum_d    = psum_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        psum_next = (psum_q >> NIBBLE_W)
                  | (WIDTH'(cla_sum) << (WIDTH - NIBBLE_W));
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
        amsb_d    = amsb_q;
        bmsb_d    = bmsb_q;
        ovf_d     = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    opa_d   = bus.a;
                    opb_d   = bus.b;
                    carry_d = bus.cin;
                    idx_d   = '0;
                    psum_d  = '0;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
                    amsb_d  = bus.a[WIDTH-1];
                    bmsb_d  = bus.b[WIDTH-1];
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                opa_d   = opa_q >> NIBBLE_W;
                opb_d   = opb_q >> NIBBLE_W;
                psum_d  = psum_next;
                carry_d = cla_cout;
                idx_d   = idx_q + IW'(1);
                if (idx_q == IW'(NIB - 1)) begin
                    sum_d   = psum_next;
                    cout_d  = cla_cout;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
                    ovf_d   = (amsb_q == bmsb_q)
                            && (psum_next[WIDTH-1] != amsb_q);
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            carry_q <= 1'b0;
            idx_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            psum_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            psum_q  <= psum_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
    // Overflow flag and the operand MSBs it is derived from.
    always_ff @(posedge clk) begin
        if (rst) begin
            amsb_q <= 1'b0;
            bmsb_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            amsb_q <= amsb_d;
            bmsb_q <= bmsb_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder: expected results are queued
// at start and compared on each done pulse, with cycle-exact timing checks.
module tb_nibble_serial_adder;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    exp_t sb[$];

    logic [W-1:0] held_sum = '0;
    logic         held_cout = 1'b0;

    nibble_serial_adder_if #(.WIDTH(W)) bus ();

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   input logic cin);
        exp_t e;
        logic [W:0] t;
        t      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        e.sum  = t[W-1:0];
        e.cout = t[W];
        e.ovf  = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
        return e;
    endfunction

    // Compare each completed result against the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sum", 32'(bus.sum), 32'(e.sum));
                chk("cout", 32'(bus.cout), 32'(e.cout));
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
                chk("ovf", 32'(bus.ovf), 32'(e.ovf));
`endif
                held_sum  = e.sum;
                held_cout = e.cout;
            end
        end
    end

    // mode 0: plain, 1: extra start in RUN cycle 2, 2: reset in RUN cycle 2.
    // Called at a negedge; returns at the negedge after the done cycle.
    task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input int mode);
        int d0;
        d0        = done_cnt;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        bus.start = 1'b1;
        if (mode != 2) sb.push_back(model(a, b, cin));
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = ~a;
        bus.b     = ~b;
        bus.cin   = ~cin;
        for (int i = 1; i <= NIB; i++) begin
            chk($sformatf("busy_c%0d", i), 32'(bus.busy), 32'd1);
            chk($sformatf("nodone_c%0d", i), 32'(bus.done), 32'd0);
            chk($sformatf("hold_sum_c%0d", i), 32'(bus.sum), 32'(held_sum));
            chk($sformatf("hold_cout_c%0d", i), 32'(bus.cout),
                32'(held_cout));
            if (mode == 1 && i == 2) begin
                bus.start = 1'b1;
                bus.a     = 16'hAAAA;
            end
            if (mode == 2 && i == 2) rst = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            if (mode == 2 && i == 2) begin
                chk("rst_busy", 32'(bus.busy), 32'd0);
                chk("rst_done", 32'(bus.done), 32'd0);
                chk("rst_sum", 32'(bus.sum), 32'd0);
                chk("rst_cout", 32'(bus.cout), 32'd0);
                rst = 1'b0;
                held_sum  = '0;
                held_cout = 1'b0;
                repeat (NIB + 2) @(negedge clk);
                chk("rst_no_done", 32'(done_cnt - d0), 32'd0);
                chk("rst_idle", 32'(bus.busy), 32'd0);
                return;
            end
        end
        chk("done_pulse", 32'(bus.done), 32'd1);
        chk("done_nobusy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        chk("done_once", 32'(bus.done), 32'd0);
        chk("done_count", 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy0", 32'(bus.busy), 32'd0);
        chk("rst_done0", 32'(bus.done), 32'd0);
        chk("rst_sum0", 32'(bus.sum), 32'd0);
        chk("rst_cout0", 32'(bus.cout), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_add(16'h0000, 16'h0000, 1'b0, 0);
        run_add(16'h1234, 16'h4321, 1'b0, 0);
        run_add(16'hFFFF, 16'h0001, 1'b0, 0);
        run_add(16'hFFFF, 16'h0000, 1'b1, 0);
        run_add(16'h0F0F, 16'h00F1, 1'b0, 1);
        run_add(16'h0001, 16'h0002, 1'b1, 0);
        run_add(16'h8000, 16'h8000, 1'b0, 2);
        run_add(16'h8000, 16'h8000, 1'b0, 0);
        run_add(16'h7FFF, 16'h0001, 1'b0, 0);
        for (int k = 0; k < 6; k++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom);
            rb = W'($urandom);
            run_add(ra, rb, 1'($urandom_range(1)), 0);
            repeat ($urandom_range(2)) @(negedge clk);
        end

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle WIDTH-bit adder. Processes one 4-bit nibble per clock through a single instance of the team's existing 4-bit carry look-ahead adder `cla` (ports A, B, Cin, Sum, Cout).
- Sits directly upstream of `cla`: latches wide operands, feeds `cla` one nibble at a time, registers the carry between nibbles and assembles the wide result.
- Trades latency for area in datapaths where a full-width adder is unnecessary.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 4. A violation raises an elaboration-time error.

Ports:
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  synchronous, active-high reset
- start  input  1  request to begin an addition; sampled only in IDLE
- a  input  WIDTH  operand A, latched when start is accepted
- b  input  WIDTH  operand B, latched when start is accepted
- cin  input  1  carry-in, latched when start is accepted
- busy  output  1  high while an addition is in progress (RUN)
- done  output  1  one-cycle pulse: result valid
- sum  output  WIDTH  registered result, held until the next completion
- cout  output  1  registered carry-out of the MSB nibble, held with sum

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: busy=0, done=0, sum=0, cout=0. Internal state: state=IDLE, carry reg=0, nibble index=0, operand/partial-sum shift regs=0.
- Reset mid-operation aborts the addition. All outputs return to reset values on the next edge, and no done pulse is produced.
- NIB = WIDTH/4.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 latches a, b, cin; carry<=cin; idx<=0; next=RUN. start=0 stays in IDLE.
  - RUN: busy=1. `cla` is driven with A=opA[3:0], B=opB[3:0], Cin=carry.
    - Each edge: opA/opB shift right by 4.
    - The Sum nibble shifts into the top of the partial-sum reg (partial sum shifts right by 4).
    - carry<=Cout; idx<=idx+1.
    - When idx==NIB-1: next=DONE, sum<=final assembled value, cout<=Cout.
  - DONE: done=1, busy=0 for exactly one cycle; next=IDLE unconditionally.
- Latency: with start accepted at the edge ending cycle T, busy is high in cycles T+1..T+NIB and done is high in cycle T+NIB+1. For WIDTH=16 that is 4 RUN cycles, and done occurs 5 cycles after start.
- Throughput: at most one addition per NIB+2 cycles. start asserted in RUN or DONE is ignored (not queued).
- sum/cout change only on the edge entering DONE; they are stable at all other times, including during RUN.
- a/b/cin changes after acceptance have no effect.
- Arithmetic is unsigned modulo 2^WIDTH; cout is the true carry-out, so {cout,sum} = a+b+cin exactly.
- Wrap-around: an all-ones operand plus carry must propagate the carry through every nibble across cycles, e.g. 0xFFFF+0x0001 gives sum=0x0000, cout=1.

Optional Feature:
- Macro: NIBBLE_SERIAL_ADDER_OVERFLOW_EN.
- Defined: adds output port ovf (1 bit, reset 0), the two's-complement signed overflow.
  - ovf = (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]), using the latched operand MSBs.
  - ovf is registered and updated together with sum/cout on the edge entering DONE, then held.
- Undefined: the ovf port and its logic do not exist; all other behaviour is identical.

Decomposition:
- Shared package arith_pkg:
  - state typedef/localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - NIBBLE_W=4
  - helper constant-function for the index width: clog2(WIDTH/4), minimum 1
- Sub-module: one instance of the existing `cla`, which is the natural combinational sub-block. The FSM, shift registers and carry register stay in nibble_serial_adder.

Test Plan:
- Reset, then a=0x0000, b=0x0000, cin=0, pulse start:
  - busy high for 4 cycles, then done pulse 5 cycles after start.
  - sum=0x0000, cout=0.
- a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0. sum holds its old value during RUN and updates only with done.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1 (carry ripples across all nibble cycles). Then a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1.
- Start 0x0F0F+0x00F1; pulse start again in RUN cycle 2 with a=0xAAAA:
  - second request ignored; exactly one done pulse.
  - sum=0x1000, cout=0.
  - A new start in the cycle after done is accepted.
- Start 0x8000+0x8000, assert rst in RUN cycle 2:
  - all outputs 0 next cycle, no done pulse.
  - A subsequent 0x8000+0x8000 gives sum=0x0000, cout=1.
- Macro defined:
  - 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1.
  - 0x8000+0x8000 -> ovf=1, cout=1.
  - 0x1234+0x4321 -> ovf=0.
